mem_write_loader: RTL and testbench

- Upstream feeder for the feature-map/weight/bias scratch memory.
- Accepts a byte stream over a valid/ready handshake and packs it into 9-byte chunks.
- Drives the memory's write port: column address, row address, 72-bit write word and 9-bit per-byte enable.
- Fills a programmed rectangular region row by row. The region can hold fmap, weight or bias data.

---
 rtl/mem_write_loader.sv | 130 +++++++++++++
 tb/tb_mem_write_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_loader.sv
// Byte-stream to scratch-memory write-port loader: packs bytes into 9-byte
// chunks and writes them row by row over a programmed rectangular region.
module mem_write_loader #(
  parameter int width    = 80,
  parameter int height   = 8,
  parameter int width_b  = 7,
  parameter int height_b = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [width_b-1:0]  base_w,
  input  logic [height_b-1:0] base_h,
  input  logic [width_b-1:0]  len_w,
  input  logic [height_b:0]   len_h,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic [width_b-1:0]  write_w,
  output logic [height_b-1:0] write_h,
  output logic [71:0]         write,
  output logic [8:0]          en
);

  // Counters get one spare bit so col_off + 9 and row == len_h never wrap.
  localparam int CW = (width_b > $clog2(width + 11)) ? width_b + 1 : $clog2(width + 11) + 1;
  localparam int RW = (height_b + 1 > $clog2(height + 1)) ? height_b + 1 : $clog2(height + 1);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, FIN} state_t;

  state_t              state, next;
  logic [width_b-1:0]  base_w_r, len_w_r;
  logic [height_b-1:0] base_h_r;
  logic [height_b:0]   len_h_r;
  logic [CW-1:0]       col_off, rem, col_sum;
  logic [RW-1:0]       row, row_next;
  logic [3:0]          k, chunk;
  logic [7:0]          slot [9];
  logic                accept, last_byte, row_wrap;
  logic [71:0]         word;
  logic [8:0]          mask;

  always_comb begin
    rem       = CW'(len_w_r) - col_off;
    chunk     = (rem >= CW'(9)) ? 4'd9 : rem[3:0];
    accept    = in_valid & in_ready & (state == FILL);
    last_byte = accept && (k == chunk - 4'd1);
    col_sum   = col_off + CW'(9);
    row_wrap  = (col_sum >= CW'(len_w_r));
    row_next  = row_wrap ? row + RW'(1) : row;
    mask      = ~(9'h1FF >> chunk);
    // The completing byte is merged in directly so ISSUE needs no extra cycle.
    word = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < 32'(chunk))
        word[71 - 8*i -: 8] = (4'(i) == k) ? in_data : slot[i];
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (start) next = ((len_w == '0) || (len_h == '0)) ? FIN : FILL;
      FILL:  if (last_byte) next = ISSUE;
      ISSUE: next = (row_next == RW'(len_h_r)) ? FIN : FILL;
      FIN:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      en       <= '0;
      write    <= '0;
      write_w  <= '0;
      write_h  <= '0;
      base_w_r <= '0;
      base_h_r <= '0;
      len_w_r  <= '0;
      len_h_r  <= '0;
      col_off  <= '0;
      row      <= '0;
      k        <= '0;
      for (int unsigned i = 0; i < 9; i++) slot[i] <= '0;
    end else begin
      in_ready <= (next == FILL);
      busy     <= (next != IDLE);
      done     <= (next == FIN);
      en       <= '0;
      case (state)
        IDLE: if (start) begin
          base_w_r <= base_w;
          base_h_r <= base_h;
          len_w_r  <= len_w;
          len_h_r  <= len_h;
          col_off  <= '0;
          row      <= '0;
          k        <= '0;
        end
        FILL: if (accept) begin
          slot[k] <= in_data;
          k       <= k + 4'd1;
          if (last_byte) begin
            en      <= mask;
            write   <= word;
            write_w <= base_w_r + col_off[width_b-1:0];
            write_h <= base_h_r + row[height_b-1:0];
          end
        end
        ISSUE: begin
          k       <= '0;
          col_off <= row_wrap ? '0 : col_sum;
          row     <= row_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_loader.sv
// Directed bench for mem_write_loader with a scoreboard of expected writes.
module tb_mem_write_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  base_w = '0;
  logic [2:0]  base_h = '0;
  logic [6:0]  len_w = '0;
  logic [3:0]  len_h = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, busy, done;
  logic [6:0]  write_w;
  logic [2:0]  write_h;
  logic [71:0] write;
  logic [8:0]  en;

  mem_write_loader #(.width(80), .height(8), .width_b(7), .height_b(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_w(base_w), .base_h(base_h),
    .len_w(len_w), .len_h(len_h), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .write_w(write_w),
    .write_h(write_h), .write(write), .en(en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  en;
    logic [71:0] wr;
    logic [6:0]  w;
    logic [2:0]  h;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_issue = 0;
  int   n_done = 0;
  bit   ready_seen = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) n_done++;
    if (in_ready === 1'b1) ready_seen = 1;
    if (en !== 9'h0) begin
      n_issue++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_issue got en=%h w=%0d h=%0d exp none", en, write_w, write_h);
      end else begin
        e = q.pop_front();
        chk("issue_en", 72'(en), 72'(e.en));
        chk("issue_data", write, e.wr);
        chk("issue_w", 72'(write_w), 72'(e.w));
        chk("issue_h", 72'(write_h), 72'(e.h));
        chk("ready_in_issue", 72'(in_ready), 72'(0));
      end
    end
  end

  // Region model: bytes are first, first+1, ... in stream order.
  task automatic push_region(input int bw, input int bh, input int lw, input int lh, input int first);
    int idx = 0;
    for (int r = 0; r < lh; r++) begin
      for (int c = 0; c < lw; c += 9) begin
        exp_t e;
        int ch = (lw - c < 9) ? lw - c : 9;
        e.wr = '0;
        e.en = '0;
        for (int s = 0; s < ch; s++) begin
          e.wr[71 - 8*s -: 8] = 8'(first + idx);
          e.en[8 - s] = 1'b1;
          idx++;
        end
        e.w = 7'((bw + c) % 128);
        e.h = 3'((bh + r) % 8);
        q.push_back(e);
      end
    end
  endtask

  task automatic kick(input int bw, input int bh, input int lw, input int lh);
    @(negedge clk);
    base_w = 7'(bw);
    base_h = 3'(bh);
    len_w  = 7'(lw);
    len_h  = 4'(lh);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic send(input int n, input int first, input bit gap);
    int   idx = 0;
    int   cyc = 0;
    bit   v = 1'b1;
    logic r;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      r        = in_ready;
      in_valid = v;
      in_data  = 8'(first + idx);
      v        = gap ? ~v : 1'b1;
      @(posedge clk);
      if (in_valid && r) idx++;
      cyc++;
      #1;
    end
    in_valid = 1'b0;
    if (idx < n) begin
      total++;
      bad++;
      $error("FAIL send_timeout got=%0d exp=%0d", idx, n);
    end
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL done_timeout got=0 exp=1");
    end
    @(negedge clk);
  endtask

  initial begin
    int c, i0, d0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_en", 72'(en), 0);
    chk("rst_busy", 72'(busy), 0);
    chk("rst_ready", 72'(in_ready), 0);
    chk("rst_done", 72'(done), 0);
    chk("rst_write", write, 0);
    chk("rst_ww", 72'(write_w), 0);
    chk("rst_wh", 72'(write_h), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single chunk with exact latency
    push_region(0, 2, 9, 1, 1);
    kick(0, 2, 9, 1);
    chk("busy_after_start", 72'(busy), 1);
    send(9, 1, 1'b0);
    @(negedge clk);
    chk("single_en", 72'(en), 72'h1FF);
    chk("single_word", write, 72'h010203040506070809);
    chk("single_done_early", 72'(done), 0);
    @(negedge clk);
    chk("single_done", 72'(done), 1);
    chk("single_busy_fin", 72'(busy), 1);
    chk("single_en_hold", 72'(en), 0);
    chk("single_write_hold", write, 72'h010203040506070809);
    @(negedge clk);
    chk("single_done_pulse", 72'(done), 0);
    chk("single_busy_drop", 72'(busy), 0);

    // multi-chunk with row wrap and partial chunk
    i0 = n_issue; d0 = n_done;
    push_region(10, 0, 20, 2, 0);
    kick(10, 0, 20, 2);
    send(40, 0, 1'b0);
    wait_done(20, c);
    chk("multi_issues", 72'(n_issue - i0), 6);
    chk("multi_done", 72'(n_done - d0), 1);
    chk("multi_queue", 72'(q.size()), 0);

    // backpressure
    i0 = n_issue;
    push_region(0, 2, 9, 1, 1);
    kick(0, 2, 9, 1);
    send(9, 1, 1'b1);
    wait_done(20, c);
    chk("bp_issues", 72'(n_issue - i0), 1);
    chk("bp_queue", 72'(q.size()), 0);

    // zero length
    i0 = n_issue; d0 = n_done;
    ready_seen = 0;
    kick(5, 1, 0, 3);
    wait_done(4, c);
    chk("zero_latency_ok", 72'(c <= 1), 1);
    chk("zero_issues", 72'(n_issue - i0), 0);
    chk("zero_ready", 72'(ready_seen), 0);
    chk("zero_done", 72'(n_done - d0), 1);

    // reset mid-operation
    push_region(0, 0, 9, 1, 0);
    kick(0, 0, 18, 1);
    send(12, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_en", 72'(en), 0);
    chk("midrst_busy", 72'(busy), 0);
    chk("midrst_ready", 72'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    i0 = n_issue; d0 = n_done;
    repeat (20) @(negedge clk);
    chk("midrst_no_issue", 72'(n_issue - i0), 0);
    chk("midrst_no_done", 72'(n_done - d0), 0);
    chk("midrst_idle", 72'(busy), 0);
    chk("midrst_queue", 72'(q.size()), 0);
    push_region(3, 4, 9, 1, 100);
    kick(3, 4, 9, 1);
    send(9, 100, 1'b0);
    wait_done(20, c);
    chk("postrst_issues", 72'(n_issue - i0), 1);
    chk("postrst_done", 72'(n_done - d0), 1);

    // start while busy is ignored
    i0 = n_issue; d0 = n_done;
    push_region(0, 1, 9, 1, 50);
    kick(0, 1, 9, 1);
    send(4, 50, 1'b0);
    kick(60, 5, 9, 1);
    send(5, 54, 1'b0);
    wait_done(20, c);
    chk("busy_start_issues", 72'(n_issue - i0), 1);
    chk("busy_start_done", 72'(n_done - d0), 1);
    chk("final_queue", 72'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
